// File: rtl/uart_frame_parser.sv
// UART frame parser: SOF, LEN, payload bytes, optional checksum byte.
// Define UART_FRAME_CHECKSUM_EN to compile in checksum verification.
module uart_frame_parser #(
   parameter int          MAX_LEN = 16,
   parameter logic [7:0]  SOF     = 8'hAA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_rd,
   output logic [7:0] m_data,
   output logic       m_valid,
   output logic       m_last,
   input  logic       m_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

`ifdef UART_FRAME_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LEN, PAYLOAD, CHK} state_t;
`else
   typedef enum logic [1:0] {IDLE, LEN, PAYLOAD} state_t;
`endif

   localparam logic [7:0] MAX8 = MAX_LEN[7:0];

   state_t     state_q, state_d;
   logic [7:0] len_q;
   logic [7:0] cnt_q;
   logic       accept;
   logic       len_ok;
   logic       is_last;

   assign accept  = m_valid & m_ready;
   assign len_ok  = (fifo_rdata != 8'd0) && (fifo_rdata <= MAX8);
   assign is_last = (cnt_q + 8'd1) == len_q;

`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0] sum_q;
   logic [7:0] chk_sum;
   logic       chk_have;
   logic       chk_good;
   logic       last_acc;
   logic       ok_q;
   logic       good_now;

   assign chk_sum  = sum_q + fifo_rdata;
   assign good_now = chk_have ? chk_good : (chk_sum == 8'd0);
   assign frame_ok = ok_q;
`else
   // Payload is final as soon as the last byte is taken downstream.
   assign frame_ok = accept & m_last;
`endif

   always_comb begin
      state_d = state_q;
      fifo_rd = 1'b0;
      unique case (state_q)
         IDLE: begin
            fifo_rd = !fifo_empty;
            if (fifo_rd && fifo_rdata == SOF) state_d = LEN;
         end
         LEN: begin
            fifo_rd = !fifo_empty;
            if (fifo_rd) state_d = len_ok ? PAYLOAD : IDLE;
         end
         PAYLOAD: begin
            fifo_rd = !fifo_empty && (!m_valid || m_ready);
`ifdef UART_FRAME_CHECKSUM_EN
            if (fifo_rd && is_last) state_d = CHK;
`else
            if (fifo_rd && is_last) state_d = IDLE;
`endif
         end
`ifdef UART_FRAME_CHECKSUM_EN
         CHK: begin
            fifo_rd = !fifo_empty && !chk_have;
            if ((chk_have || fifo_rd) &&
                (last_acc || (accept && m_last)))
               state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         cnt_q     <= '0;
         m_data    <= '0;
         m_valid   <= 1'b0;
         m_last    <= 1'b0;
         frame_err <= 1'b0;
         err_code  <= 2'b00;
`ifdef UART_FRAME_CHECKSUM_EN
         sum_q     <= '0;
         chk_have  <= 1'b0;
         chk_good  <= 1'b0;
         last_acc  <= 1'b0;
         ok_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         frame_err <= 1'b0;
         if (state_q == LEN && fifo_rd) begin
            if (len_ok) begin
               len_q <= fifo_rdata;
               cnt_q <= '0;
            end else begin
               frame_err <= 1'b1;
               err_code  <= 2'b01;
            end
         end
         if (state_q == PAYLOAD && fifo_rd) begin
            m_data  <= fifo_rdata;
            m_valid <= 1'b1;
            m_last  <= is_last;
            cnt_q   <= cnt_q + 8'd1;
         end else if (accept) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
`ifdef UART_FRAME_CHECKSUM_EN
         ok_q <= 1'b0;
         if (state_q == LEN && fifo_rd) sum_q <= fifo_rdata;
         if (state_q == PAYLOAD && fifo_rd) begin
            sum_q <= chk_sum;
            if (is_last) begin
               chk_have <= 1'b0;
               last_acc <= 1'b0;
            end
         end
         if (state_q == CHK) begin
            if (fifo_rd) begin
               chk_have <= 1'b1;
               chk_good <= (chk_sum == 8'd0);
            end
            if (accept && m_last) last_acc <= 1'b1;
            if (state_d == IDLE) begin
               ok_q      <= good_now;
               frame_err <= !good_now;
               if (!good_now) err_code <= 2'b10;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: random frames vs queue model.
module tb_uart_frame_parser;

   localparam logic [7:0] SOF = 8'hAA;
   localparam int         MAX = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_rdata = 8'h00;
   logic       fifo_rd;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready = 1'b0;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   int checks = 0;
   int failures = 0;
   int gap_pct = 0;
   int rdy_pct = 100;

   logic [7:0] fq[$];
   logic [7:0] pl[$];
   logic [8:0] exp_data[$];
   int         exp_done[$];
   int         exp_len[$];

   always #5 clk = ~clk;

   uart_frame_parser dut (
      .clk(clk), .rst(rst),
      .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_rd(fifo_rd),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
      .m_ready(m_ready),
      .frame_ok(frame_ok), .frame_err(frame_err),
      .err_code(err_code)
   );

   function automatic void check(string name, logic [31:0] act,
                                 logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Upstream FIFO model with random bubbles and random downstream ready.
   initial begin
      bit pop;
      forever begin
         @(negedge clk);
         pop = fifo_rd;
         if (rst) check("rd_while_empty", {31'd0, fifo_rd & fifo_empty}, 0);
         @(posedge clk);
         #1;
         if (pop && fq.size() > 0) void'(fq.pop_front());
         fifo_empty = (fq.size() == 0) ||
                      ($urandom_range(0, 99) < gap_pct);
         fifo_rdata = fifo_empty ? 8'($urandom) : fq[0];
         m_ready = ($urandom_range(0, 99) < rdy_pct);
      end
   end

   // Monitor: pops expected beats and frame events as the DUT shows them.
   initial begin
      logic       stall;
      logic [7:0] hd;
      logic       hl;
      int         k;
      stall = 1'b0;
      hd = '0;
      hl = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stall = 1'b0;
         end else begin
            if (stall)
               check("hold_stable", {22'd0, m_valid, m_last, m_data},
                     {22'd0, 1'b1, hl, hd});
            if (m_valid && m_ready) begin
               check("data_expected", exp_data.size() > 0, 1);
               if (exp_data.size() > 0)
                  check("data", {m_last, m_data}, exp_data.pop_front());
            end
            stall = m_valid && !m_ready;
            hd = m_data;
            hl = m_last;
            if (frame_ok && frame_err)
               check("ok_and_err", 1, 0);
            if (frame_ok) begin
               check("ok_expected", exp_done.size() > 0, 1);
               if (exp_done.size() > 0) begin
                  k = exp_done.pop_front();
                  check("ok_kind", 0, k);
               end
            end
            if (frame_err) begin
               if (err_code == 2'b01) begin
                  check("len_err_expected", exp_len.size() > 0, 1);
                  if (exp_len.size() > 0) void'(exp_len.pop_front());
               end else begin
                  check("chk_err_expected", exp_done.size() > 0, 1);
                  if (exp_done.size() > 0) begin
                     k = exp_done.pop_front();
                     check("err_code", {30'd0, err_code}, (k == 2) ? 2 : 1);
                  end
               end
            end
         end
      end
   end

   // Reference: frame is SOF, LEN, payload, then optional checksum byte.
   task automatic push_frame(input logic [7:0] len, input int chk_off);
      logic [7:0] s;
      logic [7:0] b;
      fq.push_back(SOF);
      fq.push_back(len);
      if (len == 0 || int'(len) > MAX) begin
         exp_len.push_back(1);
         pl.delete();
         return;
      end
      s = len;
      for (int i = 0; i < int'(len); i++) begin
         if (pl.size() > 0) b = pl.pop_front();
         else begin
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = SOF;
         end
         fq.push_back(b);
         exp_data.push_back({(i == int'(len) - 1), b});
         s = s + b;
      end
`ifdef UART_FRAME_CHECKSUM_EN
      b = 8'(0 - s) + 8'(chk_off);
      fq.push_back(b);
      exp_done.push_back((chk_off % 256 == 0) ? 0 : 2);
`else
      exp_done.push_back(chk_off - chk_off);
`endif
      pl.delete();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fq.size() > 0 || exp_data.size() > 0 || exp_done.size() > 0 ||
              exp_len.size() > 0 || m_valid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", n < 3000, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_valid && n < 500);
      check("valid_in_time", m_valid, 1);
   endtask

   initial begin
      logic [7:0] jb;
      int nj;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {fifo_rd, m_valid, m_last, m_data,
                            frame_ok, frame_err, err_code}, 0);
      @(negedge clk);
      rst = 1'b1;

      gap_pct = 0;
      rdy_pct = 100;
      pl = '{8'h11, 8'h22, 8'h33};
      push_frame(8'd3, 0);
      wait_valid();
      check("b2b_0", {m_valid, m_data}, {1'b1, 8'h11});
      @(negedge clk);
      check("b2b_1", {m_valid, m_data}, {1'b1, 8'h22});
      @(negedge clk);
      check("b2b_2", {m_valid, m_last, m_data}, {2'b11, 8'h33});
      drain();

      fq.push_back(SOF); fq.push_back(8'h00); exp_len.push_back(1);
      fq.push_back(SOF); fq.push_back(8'h11); exp_len.push_back(1);
      push_frame(8'd16, 0);
      drain();

      fq.push_back(8'h55); fq.push_back(SOF); fq.push_back(SOF);
      fq.push_back(8'h01); fq.push_back(8'h77);
      exp_len.push_back(1);
      drain();

`ifdef UART_FRAME_CHECKSUM_EN
      pl = '{8'h10, 8'h20};
      push_frame(8'd2, 0);
      pl = '{8'h10, 8'h20};
      push_frame(8'd2, 1);
      drain();
`endif

      rdy_pct = 0;
      pl = '{8'h41, 8'h42};
      push_frame(8'd2, 0);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         check("stall_hold", {m_valid, fifo_rd, m_data}, {2'b10, 8'h41});
         @(negedge clk);
      end
      rdy_pct = 100;
      drain();

      gap_pct = 30;
      rdy_pct = 70;
      for (int f = 0; f < 40; f++) begin
         nj = $urandom_range(0, 2);
         for (int j = 0; j < nj; j++) begin
            do jb = 8'($urandom); while (jb == SOF);
            fq.push_back(jb);
         end
         if ($urandom_range(0, 4) == 0)
            push_frame(($urandom_range(0, 1) == 1) ? 8'd0 :
                       8'($urandom_range(MAX + 1, 255)), 0);
         else
            push_frame(8'($urandom_range(1, MAX)),
                       ($urandom_range(0, 1) == 1) ?
                       $urandom_range(1, 255) : 0);
         if (f % 10 == 9) drain();
      end
      drain();

      gap_pct = 0;
      rdy_pct = 0;
      push_frame(8'd3, 0);
      wait_valid();
      @(posedge clk);
      #3;
      fq.delete();
      exp_data.delete();
      exp_done.delete();
      exp_len.delete();
      fifo_empty = 1'b1;
      rst = 1'b0;
      #1;
      check("async_reset", {fifo_rd, m_valid, m_last, m_data,
                            frame_ok, frame_err, err_code}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      rdy_pct = 100;
      pl = '{8'h5A};
      push_frame(8'd1, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum legal payload length in bytes (1..255).
REQ-002 SHALL have parameter SOF, default 8'hAA, start-of-frame byte value.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 fifo_empty  input  1  upstream RX FIFO empty flag.
REQ-006 fifo_rdata  input  8  upstream FIFO head byte, first-word-fall-through, valid while fifo_empty=0.
REQ-007 fifo_rd  output  1  pop strobe to upstream FIFO; one byte consumed per cycle asserted.
REQ-008 m_data  output  8  payload byte out.
REQ-009 m_valid  output  1  m_data valid.
REQ-010 m_last  output  1  m_data is final payload byte of frame.
REQ-011 m_ready  input  1  downstream accepts m_data when m_valid=1.
REQ-012 frame_ok  output  1  one-cycle pulse, frame completed without error.
REQ-013 frame_err  output  1  one-cycle pulse, frame aborted or rejected.
REQ-014 err_code  output  2  cause, held until next frame_err: 01 bad length, 10 checksum mismatch.

Function
REQ-015 fifo_rd SHALL never assert while fifo_empty=1.
REQ-016 FSM states: IDLE, LEN, PAYLOAD, CHK (CHK only with CHECKSUM_EN).
REQ-017 IDLE: pop every byte; byte==SOF -> LEN; any other byte discarded silently, stay IDLE.
REQ-018 LEN: pop one byte; value 1..MAX_LEN -> latch length, clear byte counter, PAYLOAD; value 0 or >MAX_LEN -> frame_err, err_code=01, IDLE.
REQ-019 PAYLOAD: fifo_rd = !fifo_empty && (!m_valid || m_ready); popped byte appears on m_data with m_valid=1 on next cycle.
REQ-020 m_data/m_valid/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-021 m_valid SHALL deassert after acceptance unless a new byte is popped in that same cycle (back-to-back throughput 1 byte/cycle).
REQ-022 m_last=1 exactly on byte number length; after popping it FSM leaves PAYLOAD (CHK or IDLE).
REQ-023 Without checksum: frame_ok pulses the cycle m_last byte is accepted (m_valid&m_ready&m_last).
REQ-024 Byte counter 8 bits, no wrap possible since length<=255.
REQ-025 A SOF value inside LEN/PAYLOAD/CHK SHALL be treated as data, not resync.
REQ-026 fifo_rd and m_data consumption SHALL be independent of upstream full flags; parser stalls only on fifo_empty or m_ready.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, fifo_rd=0, m_valid=0, m_last=0, m_data=0, frame_ok=0, frame_err=0, err_code=00, counters=0.
REQ-028 Reset mid-frame discards partial frame; no frame_ok/frame_err emitted for it.
REQ-029 First pop permitted on first rising edge after rst deasserts.

Configuration
REQ-030 Macro UART_FRAME_CHECKSUM_EN SHALL compile in checksum checking.
REQ-031 With it: after last payload byte, CHK pops one byte; (LEN + all payload + CHK) mod 256 == 0 -> frame_ok, else frame_err, err_code=10; pulse on cycle after CHK pop and after m_last accepted, whichever later; then IDLE.
REQ-032 With it, payload is forwarded before verification; downstream SHALL rely on frame_ok/frame_err.
REQ-033 Without it: no CHK state, no sum register, err_code 10 never produced.

Verification
REQ-034 FIFO holds AA 03 11 22 33, m_ready=1, no checksum -> m_data 11,22,33 on consecutive cycles, m_last on 33, frame_ok once.
REQ-035 With CHECKSUM_EN, AA 02 10 20 CE -> payload 10,20, frame_ok; same with last byte CF -> frame_err, err_code=10.
REQ-036 AA 00 then AA 11 (MAX_LEN=16) -> frame_err err_code=01 each, no m_valid, FSM back to IDLE.
REQ-037 Junk 55 AA AA 01 77 -> 55 dropped, second AA taken as length-error? No: second AA is length 170 -> frame_err 01; following 01 77 dropped in IDLE.
REQ-038 AA 02 41 42 with m_ready=0 for 5 cycles -> m_data=41 held stable, fifo_rd=0, then resumes, frame_ok after 42.
REQ-039 rst=0 asserted while in PAYLOAD after 1 of 3 bytes -> all outputs zero immediately, no frame_ok/frame_err, next AA 01 5A parsed normally.
